// File: rtl/game_pkg.sv
// Shared definitions for the game sources on the 4-bit display mux.
//   VAL_BLANK / VAL_FAIL : reserved display codes
//   state_t              : reaction-game FSM states
//   lfsr_next            : one step of the 8-bit x^8+x^6+x^5+x^4+1 Fibonacci LFSR
package game_pkg;

    localparam logic [3:0] VAL_BLANK = 4'd12;
    localparam logic [3:0] VAL_FAIL  = 4'd15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        TARGET = 3'd2,
        RESULT = 3'd3,
        FAIL   = 3'd4
    } state_t;

    // Shift left; feedback taps are bits 8,6,5,4 in polynomial numbering.
    function automatic logic [7:0] lfsr_next(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    endfunction

endpackage

// File: rtl/game_reaction_if.sv
// Button/display bundle of the reaction game.
//   btn1..btn4 : debounced, game-gated single-cycle button pulses
//   value      : 4-bit display code towards the display mux
// master = button/display side, slave = game core.
interface game_reaction_if;

    logic       btn1;
    logic       btn2;
    logic       btn3;
    logic       btn4;
    logic [3:0] value;

    modport master (
        output btn1, btn2, btn3, btn4,
        input  value
    );

    modport slave (
        input  btn1, btn2, btn3, btn4,
        output value
    );

endinterface

// File: rtl/reaction_lfsr.sv
// Free-running 8-bit pseudo-random source, reusable by other games.
//   clk   : system clock
//   reset : asynchronous, active-high; loads SEED
//   rnd   : current LFSR state, advances every clk, never 0 for a non-zero SEED
module reaction_lfsr
    import game_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] rnd
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rnd <= SEED;
        end else begin
            rnd <= lfsr_next(rnd);
        end
    end

endmodule

// File: rtl/game_reaction.sv
// Reaction-time game (display mux source 2'b11).
// After a random delay a target digit 1..4 is shown; the player presses the
// matching button and gets a 0..9 score (lower is faster) or the fail code.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : slave side of game_reaction_if (btn1..btn4 in, value out)
// value is fully registered: 12 blank, 1..4 target, 0..9 score, 15 fail.
module game_reaction
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 100000,
    parameter int unsigned MIN_DELAY     = 100,
    parameter int unsigned SCORE_TICKS   = 10,
    parameter int unsigned TIMEOUT_TICKS = 200
) (
    input  logic            clk,
    input  logic            reset,
    game_reaction_if.slave  bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = $clog2(MIN_DELAY + 256);
    localparam int unsigned RW = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned SW = (SCORE_TICKS > 1) ? $clog2(SCORE_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] RT_MAX    = RW'(TIMEOUT_TICKS);
    localparam logic [SW-1:0] SDIV_MAX  = SW'(SCORE_TICKS - 1);

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [DW-1:0] delay_q;
    logic [RW-1:0] rt_q;
    logic [SW-1:0] sdiv_q;
    logic [3:0]    score_q;
    logic [1:0]    tidx_q;
    logic [3:0]    value_q;

    logic [7:0]    rnd;
    logic [3:0]    btn_vec;
    logic [3:0]    match_mask;
    logic          any;
    logic          tick;
    logic [DW-1:0] new_delay;

    reaction_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .rnd   (rnd)
    );

    assign btn_vec    = {bus.btn4, bus.btn3, bus.btn2, bus.btn1};
    assign any        = |btn_vec;
    assign match_mask = 4'b0001 << tidx_q;
    assign tick       = (presc_q == PRESC_MAX);
    assign new_delay  = DW'(MIN_DELAY) + DW'(rnd);
    assign bus.value  = value_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            delay_q <= '0;
            rt_q    <= '0;
            sdiv_q  <= '0;
            score_q <= '0;
            tidx_q  <= '0;
            value_q <= VAL_BLANK;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);

            // Every branch that changes state also clears the prescaler so the
            // first tick of the new state lands exactly TICK_DIV cycles later.
            unique case (state_q)
                IDLE, RESULT, FAIL: begin
                    if (any) begin
                        state_q <= WAIT;
                        delay_q <= new_delay;
                        presc_q <= '0;
                        value_q <= VAL_BLANK;
                    end
                end

                WAIT: begin
                    if (any) begin
                        state_q <= FAIL;
                        presc_q <= '0;
                        value_q <= VAL_FAIL;
                    end else if (tick) begin
                        if (delay_q <= DW'(1)) begin
                            state_q <= TARGET;
                            delay_q <= '0;
                            presc_q <= '0;
                            tidx_q  <= rnd[1:0];
                            value_q <= {2'b00, rnd[1:0]} + 4'd1;
                            rt_q    <= '0;
                            sdiv_q  <= '0;
                            score_q <= '0;
                        end else begin
                            delay_q <= delay_q - DW'(1);
                        end
                    end
                end

                TARGET: begin
                    // A press is evaluated before the timeout, so a correct
                    // press in the timeout cycle still scores.
                    if (any) begin
                        presc_q <= '0;
                        if (btn_vec == match_mask) begin
                            state_q <= RESULT;
                            value_q <= score_q;
                        end else begin
                            state_q <= FAIL;
                            value_q <= VAL_FAIL;
                        end
                    end else if (rt_q == RT_MAX) begin
                        state_q <= FAIL;
                        presc_q <= '0;
                        value_q <= VAL_FAIL;
                    end else if (tick) begin
                        rt_q <= rt_q + RW'(1);
                        // score tracks min(rt/SCORE_TICKS, 9) without a divider
                        if (sdiv_q == SDIV_MAX) begin
                            sdiv_q <= '0;
                            if (score_q != 4'd9) begin
                                score_q <= score_q + 4'd1;
                            end
                        end else begin
                            sdiv_q <= sdiv_q + SW'(1);
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    value_q <= VAL_BLANK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_reaction.sv
// Self-checking bench for game_reaction with small timing parameters.
// The reference model works on edge numbers: a press applied at edge k into
// WAIT schedules TARGET at edge k + TICK_DIV*(MIN_DELAY + lfsr(k)), and a
// press at edge p in TARGET scores from the number of ticks elapsed since entry.
module tb_game_reaction;

    localparam int unsigned TICK_DIV      = 4;
    localparam int unsigned MIN_DELAY     = 2;
    localparam int unsigned SCORE_TICKS   = 2;
    localparam int unsigned TIMEOUT_TICKS = 20;

    logic clk = 1'b0;
    logic reset;
    game_reaction_if bus ();

    game_reaction #(
        .TICK_DIV      (TICK_DIV),
        .MIN_DELAY     (MIN_DELAY),
        .SCORE_TICKS   (SCORE_TICKS),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Number of rising edges since reset was released.
    int cyc = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int n_vec = 0;
    int n_bad = 0;
    int t_edge;   // predicted edge at which TARGET is entered

    // LFSR state seen just before edge k (seed A5 before the first edge).
    function automatic logic [7:0] lfsr_at(input int k);
        logic [7:0] r;
        r = 8'hA5;
        for (int i = 1; i < k; i++) r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
        return r;
    endfunction

    function automatic int exp_score(input int p);
        int ticks;
        int s;
        ticks = (p - t_edge - 1) / TICK_DIV;
        if (ticks > TIMEOUT_TICKS) ticks = TIMEOUT_TICKS;
        s = ticks / SCORE_TICKS;
        return (s > 9) ? 9 : s;
    endfunction

    function automatic logic [3:0] mask_of(input int t);
        logic [3:0] m;
        m = 4'b0001;
        return m << (t - 1);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic [3:0] m);
        {bus.btn4, bus.btn3, bus.btn2, bus.btn1} = m;
    endtask

    // Called at a falling edge; pulse lands on the next rising edge k.
    task automatic apply(input logic [3:0] m, output int k);
        drive(m);
        k = cyc + 1;
        @(negedge clk);
        drive(4'b0000);
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic start_round(input logic [3:0] m, input string tag);
        int k;
        logic [7:0] r;
        apply(m, k);
        check(tag, int'(bus.value), 12);
        r = lfsr_at(k);
        t_edge = k + TICK_DIV * (MIN_DELAY + int'(r));
    endtask

    task automatic await_target(output int tgt);
        int guard;
        logic [7:0] r;
        guard = 0;
        while (bus.value == 4'd12 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("tgt_time", cyc, t_edge);
        r = lfsr_at(t_edge);
        tgt = int'(r[1:0]) + 1;
        check("tgt_val", int'(bus.value), tgt);
    endtask

    task automatic press_at(input int p, input logic [3:0] m, input int exp, input string tag);
        int k;
        wait_to(p - 1);
        apply(m, k);
        check(tag, int'(bus.value), exp);
    endtask

    function automatic logic [3:0] other_mask(input int t);
        int o;
        o = ((t - 1 + 1 + int'($urandom_range(0, 2))) % 4) + 1;
        return mask_of(o);
    endfunction

    function automatic logic [3:0] rand_mask();
        logic [3:0] m;
        m = 4'($urandom_range(1, 15));
        return m;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        int tgt;
        int k;
        int p;
        int act;

        reset = 1'b1;
        drive(4'b0000);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_val", int'(bus.value), 12);

        // Idle with no pulses stays blank.
        for (int i = 0; i < 10; i++) begin
            repeat (100) @(negedge clk);
            check("idle_blank", int'(bus.value), 12);
        end

        // False start in WAIT.
        start_round(4'b0001, "idle_to_wait");
        repeat (2) @(negedge clk);
        apply(4'b0010, k);
        check("false_start", int'(bus.value), 15);

        // Correct press 5 ticks after entry, then btn3 starts a new round.
        start_round(4'b0100, "fail_to_wait");
        await_target(tgt);
        p = t_edge + 1 + 5 * TICK_DIV;
        press_at(p, mask_of(tgt), exp_score(p), "score_5ticks");
        start_round(4'b0100, "result_to_wait");

        // Wrong button, then matching+wrong together.
        await_target(tgt);
        press_at(t_edge + 3, other_mask(tgt), 15, "wrong_btn");
        start_round(4'b1000, "next_round");
        await_target(tgt);
        press_at(t_edge + 7, mask_of(tgt) | other_mask(tgt), 15, "double_btn");
        start_round(4'b0001, "next_round");

        // Timeout, press at tick 19, press in the timeout cycle itself.
        await_target(tgt);
        wait_to(t_edge + TICK_DIV * TIMEOUT_TICKS);
        check("pre_timeout", int'(bus.value), tgt);
        wait_to(t_edge + TICK_DIV * TIMEOUT_TICKS + 1);
        check("timeout", int'(bus.value), 15);
        start_round(4'b0010, "next_round");
        await_target(tgt);
        press_at(t_edge + 1 + 19 * TICK_DIV, mask_of(tgt), 9, "score_sat");
        start_round(4'b0010, "next_round");
        await_target(tgt);
        press_at(t_edge + 1 + TIMEOUT_TICKS * TICK_DIV, mask_of(tgt), 9, "press_at_timeout");
        start_round(rand_mask(), "next_round");

        // Randomised rounds.
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                apply(rand_mask(), k);
                check("rand_false_start", int'(bus.value), 15);
                start_round(rand_mask(), "rand_restart");
            end
            await_target(tgt);
            act = int'($urandom_range(0, 3));
            p = t_edge + int'($urandom_range(1, TICK_DIV * TIMEOUT_TICKS + 1));
            case (act)
                0: press_at(p, mask_of(tgt), exp_score(p), "rand_score");
                1: press_at(p, other_mask(tgt), 15, "rand_wrong");
                2: press_at(p, mask_of(tgt) | other_mask(tgt), 15, "rand_double");
                default: begin
                    wait_to(t_edge + TICK_DIV * TIMEOUT_TICKS + 1);
                    check("rand_timeout", int'(bus.value), 15);
                end
            endcase
            start_round(rand_mask(), "rand_next");
        end

        // Asynchronous reset in the middle of TARGET.
        await_target(tgt);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", int'(bus.value), 12);
        @(negedge clk);
        reset = 1'b0;
        start_round(4'b0001, "fresh_wait");
        await_target(tgt);
        p = t_edge + 1 + 3 * TICK_DIV;
        press_at(p, mask_of(tgt), exp_score(p), "fresh_score");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
